// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file, two byte-enabled write ports,
//              optional write-to-read bypass and a pending-write scoreboard.
// Revision   : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    output logic [NRD-1:0]           rbusy,
    input  logic [DATA_W/8-1:0]      we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W/8-1:0]      we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     flush,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int C_DEPTH = 2**ADDR_W;
    localparam int C_NB    = DATA_W/8;

    logic [DATA_W-1:0]  mem_q [C_DEPTH];
    logic [DATA_W-1:0]  mem_d [C_DEPTH];
    logic [C_DEPTH-1:0] busy_q;
    logic [C_DEPTH-1:0] busy_d;

    logic w0_act;
    logic w1_act;

    assign w0_act = |we0;
    assign w1_act = |we1;

    // Port 1 is applied after port 0 so it wins on bytes both enable.
    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < C_NB; b++) begin
            if (we0[b] && (waddr0 != '0)) mem_d[waddr0][b*8 +: 8] = wdata0[b*8 +: 8];
        end
        for (int b = 0; b < C_NB; b++) begin
            if (we1[b] && (waddr1 != '0)) mem_d[waddr1][b*8 +: 8] = wdata1[b*8 +: 8];
        end
    end

    // A new producer (set) supersedes a retiring one (clear) on the same register.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (w0_act)   busy_d[waddr0]   = 1'b0;
            if (w1_act)   busy_d[waddr1]   = 1'b0;
            if (set_busy) busy_d[set_addr] = 1'b1;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < C_DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              wr_hit;

        assign ra     = raddr[k*ADDR_W +: ADDR_W];
        assign wr_hit = (w0_act && (waddr0 == ra)) || (w1_act && (waddr1 == ra));

        always_comb begin
            rd = mem_q[ra];
            if (BYPASS != 0) begin
                for (int b = 0; b < C_NB; b++) begin
                    if (we1[b] && (waddr1 == ra))      rd[b*8 +: 8] = wdata1[b*8 +: 8];
                    else if (we0[b] && (waddr0 == ra)) rd[b*8 +: 8] = wdata0[b*8 +: 8];
                end
            end
            if (ra == '0) rd = '0;
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
        assign rbusy[k] = busy_q[ra] && (ra != '0) && !((BYPASS != 0) && wr_hit);
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the five-stage pipeline.
- Replaces the fixed 32x32, 2-read/1-write file.
- Adds:
  - configurable data width, depth and read-port count
  - two byte-enabled write ports (WB, plus a second port for a late-retiring unit such as mul/div or load)
  - optional same-cycle write-to-read bypass
  - a per-register pending-write scoreboard that the ID stage uses for hazard detection

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = read data reflects same-cycle writes; 0 = read data shows only the stored value.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous reset, active-low.
- raddr, input, NRD*ADDR_W, read addresses; port k is at bits [k*ADDR_W +: ADDR_W].
- rdata, output, NRD*DATA_W, read data; port k is at bits [k*DATA_W +: DATA_W].
- rbusy, output, NRD, bit k = 1 when raddr[k] has an outstanding producer.
- we0, input, DATA_W/8, byte write enables, port 0.
- waddr0, input, ADDR_W, write address, port 0.
- wdata0, input, DATA_W, write data, port 0.
- we1, input, DATA_W/8, byte write enables, port 1.
- waddr1, input, ADDR_W, write address, port 1.
- wdata1, input, DATA_W, write data, port 1.
- set_busy, input, 1, marks register set_addr as pending (issued producer).
- set_addr, input, ADDR_W, register to mark pending.
- flush, input, 1, clears every busy bit (pipeline flush / exception).
- busy_vec, output, 2**ADDR_W, raw scoreboard state for debug.

Behaviour:
- Reset:
  - Sampled on the clk edge when reset==0.
  - Next cycle: all registers = 0, all busy bits = 0, busy_vec = 0.
  - All writes, set_busy and flush presented in a reset cycle are ignored.
  - Reset in the middle of an operation discards any pending writes.
- Register 0:
  - Always reads 0.
  - Never written.
  - Never busy; set_busy to address 0 is ignored.
- Write:
  - Occurs on the rising edge.
  - Byte i of the register takes wdataN[8i+7:8i] when weN[i]=1; otherwise byte i keeps its value.
  - Both ports target the same address in the same cycle: merge per byte; port 1 wins on bytes enabled by both.
- Read:
  - Combinational, zero latency.
  - BYPASS=1: each byte of rdata[k] is the same-cycle write byte when the address matches and that byte is enabled (port 1 over port 0, then the stored value). Address 0 still reads 0.
  - BYPASS=0: rdata is the stored value only.
- Scoreboard: busy[a] next-state priority, highest first:
  1. reset
  2. flush → 0
  3. set_busy && set_addr==a && a!=0 → 1. Set wins over a same-cycle clear, because a new producer supersedes the retiring one.
  4. any write port with weN!=0 and waddrN==a → 0
  5. hold
- rbusy:
  - rbusy[k] = busy[raddr[k]] with a same-cycle clear applied: a port writing raddr[k] this cycle (weN!=0) forces rbusy[k]=0 when BYPASS=1.
  - rbusy[k] = 0 for address 0.
  - A same-cycle set_busy does not raise rbusy until the next cycle.
- Writes with weN==0 change neither data nor busy state.
- Writes to a non-busy register are legal and update data normally.
- Zero-width and out-of-range cases do not exist; all addresses are in range by construction.

Test Plan:
- Reset: hold reset=0 for 2 cycles after writing 0xDEADBEEF to r5 → r5 reads 0x00000000, busy_vec==0.
- Byte enables: write 0x11223344 to r3 with we0=4'hF, then 0xAABBCCDD with we0=4'b0101 → r3 reads 0x11BB33DD.
- Dual-write conflict: same cycle, port 0 writes 0x000000FF to r7 (we0=4'hF), port 1 writes 0xFF000000 to r7 (we1=4'b1000) → r7 reads 0xFF0000FF.
- Bypass: BYPASS=1, same cycle write 0x12345678 to r9 and raddr[0]=9 → rdata[0]=0x12345678 in that cycle. BYPASS=0 → old value in that cycle, new value next cycle.
- Scoreboard:
  - set_busy for r4 → rbusy=1 from the next cycle.
  - set_busy r4 together with a port-1 write to r4 in the same cycle → stays busy.
  - Later port-0 write to r4 → rbusy=0 in the write cycle (BYPASS=1); busy_vec[4]=0 next cycle.
- Flush and r0:
  - Mark r2, r6 and r31 busy, then assert flush → busy_vec==0 next cycle.
  - set_busy with set_addr=0, or a write of 0xFFFFFFFF to r0 → r0 reads 0, busy_vec[0]=0.
